// File: rtl/pe_pkg.sv
// pe_pkg: shared types and helpers for the PE array result path.
//   drain_state_e : state encoding of the result drain FSM
//   pe_idx_width  : width of a row/column index for an N-PE array
package pe_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } drain_state_e;

  function automatic int pe_idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/result_saturate.sv
// result_saturate: narrows a signed PE total to the output element width.
// Build option: RESULT_SAT_EN
//   defined   -> clamp to the signed OUT_WIDTH range, sat flags a clamp
//   undefined -> keep the low OUT_WIDTH bits, sat is tied low
// Ports:
//   in_total  in  ACCUM_WIDTH  signed PE total
//   out_data  out OUT_WIDTH    narrowed element
//   sat       out 1            element was clamped
module result_saturate
  import pe_pkg::*;
#(
  parameter int ACCUM_WIDTH = 32,
  parameter int OUT_WIDTH   = 32
) (
  input  logic [ACCUM_WIDTH-1:0] in_total,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   sat
);

  generate
    if (OUT_WIDTH == ACCUM_WIDTH) begin : g_pass
      assign out_data = in_total;
      assign sat      = 1'b0;
    end else begin : g_narrow
`ifdef RESULT_SAT_EN
      // The value fits when every bit from the output sign bit upward
      // is a copy of the accumulator sign bit.
      logic [ACCUM_WIDTH-OUT_WIDTH:0] hi;
      logic                           in_range;
      assign hi       = in_total[ACCUM_WIDTH-1:OUT_WIDTH-1];
      assign in_range = (hi == '0) || (&hi);
      assign sat      = ~in_range;
      assign out_data = in_range              ? in_total[OUT_WIDTH-1:0] :
                        in_total[ACCUM_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                                                  {1'b0, {(OUT_WIDTH-1){1'b1}}};
`else
      logic unused_hi;
      assign unused_hi = ^in_total[ACCUM_WIDTH-1:OUT_WIDTH];
      assign out_data  = in_total[OUT_WIDTH-1:0];
      assign sat       = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: rtl/pe_result_drain.sv
// pe_result_drain: captures one column of N PE results and serializes it
// onto a valid/ready stream in row order, then advances the column.
// Build option: RESULT_SAT_EN (saturating narrowing in result_saturate).
//
// state   | meaning
// COLLECT | waiting for every PE of the current column to report
// DRAIN   | presenting cap_*[row] until row N-1 is accepted
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pe_done/total/err   per-PE result pulse, value and error flag
//   collect_ready       controller may start the PEs
//   out_valid/ready     element stream handshake
//   out_data/row/col    element C[row,col]
//   out_err, out_sat    captured PE error, element was clamped
//   matrix_done         pulse after the last element of column N-1
//   overflow_err        sticky: a result arrived with nowhere to go
module pe_result_drain
  import pe_pkg::*;
#(
  parameter int  N           = 8,
  parameter int  ACCUM_WIDTH = 32,
  parameter int  OUT_WIDTH   = 32,
  localparam int IDX_WIDTH   = pe_idx_width(N)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N-1:0]                    pe_done,
  input  logic [N-1:0][ACCUM_WIDTH-1:0]   pe_total,
  input  logic [N-1:0]                    pe_err,
  output logic                            collect_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_WIDTH-1:0]            out_data,
  output logic [IDX_WIDTH-1:0]            out_row,
  output logic [IDX_WIDTH-1:0]            out_col,
  output logic                            out_err,
  output logic                            out_sat,
  output logic                            matrix_done,
  output logic                            overflow_err
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N - 1);

  drain_state_e           state;
  logic [N-1:0]           cap_vld;
  logic [N-1:0]           cap_err;
  logic [ACCUM_WIDTH-1:0] cap_total [N];
  logic [IDX_WIDTH-1:0]   row;
  logic [IDX_WIDTH-1:0]   col;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= COLLECT;
      cap_vld      <= '0;
      cap_err      <= '0;
      row          <= '0;
      col          <= '0;
      matrix_done  <= 1'b0;
      overflow_err <= 1'b0;
      for (int p = 0; p < N; p++) cap_total[p] <= '0;
    end else begin
      matrix_done <= 1'b0;
      case (state)
        COLLECT: begin
          // A PE reporting into an already-filled slot is dropped.
          for (int p = 0; p < N; p++) begin
            if (pe_done[p] && !cap_vld[p]) begin
              cap_total[p] <= pe_total[p];
              cap_err[p]   <= pe_err[p];
            end
          end
          cap_vld <= cap_vld | pe_done;
          if (|(pe_done & cap_vld)) overflow_err <= 1'b1;
          if (&(cap_vld | pe_done)) begin
            state <= DRAIN;
            row   <= '0;
          end
        end
        DRAIN: begin
          if (|pe_done) overflow_err <= 1'b1;
          if (out_ready) begin
            if (row == LAST_IDX) begin
              row     <= '0;
              cap_vld <= '0;
              state   <= COLLECT;
              if (col == LAST_IDX) begin
                col         <= '0;
                matrix_done <= 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end else begin
              row <= row + 1'b1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  result_saturate #(
    .ACCUM_WIDTH (ACCUM_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH)
  ) u_sat (
    .in_total (cap_total[row]),
    .out_data (out_data),
    .sat      (out_sat)
  );

  assign out_valid     = (state == DRAIN);
  assign out_err       = cap_err[row];
  assign out_row       = row;
  assign out_col       = col;
  assign collect_ready = (state == COLLECT) && (cap_vld == '0);

endmodule

// File: tb/tb_pe_result_drain.sv
module tb_pe_result_drain;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int OW = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N-1:0]          pe_done = '0;
  logic [N-1:0][AW-1:0]  pe_total = '0;
  logic [N-1:0]          pe_err = '0;
  logic                  out_ready = 1'b0;
  logic                  collect_ready, out_valid, out_err, out_sat;
  logic                  matrix_done, overflow_err;
  logic [OW-1:0]         out_data;
  logic [1:0]            out_row, out_col;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  pe_result_drain #(.N(N), .ACCUM_WIDTH(AW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .pe_done(pe_done), .pe_total(pe_total),
    .pe_err(pe_err), .collect_ready(collect_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_col(out_col), .out_err(out_err), .out_sat(out_sat),
    .matrix_done(matrix_done), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [OW-1:0] data;
    int            row;
    int            col;
    logic          err;
    logic          sat;
  } beat_t;

  beat_t        q[$];
  logic [N-1:0] m_have;
  logic [N-1:0] m_err;
  longint       m_tot [N];
  int           m_col;
  logic         m_ovf, m_mdone;

  function automatic logic [OW-1:0] exp_data(input longint v);
`ifdef RESULT_SAT_EN
    longint mx = (longint'(1) << (OW - 1)) - 1;
    longint mn = -(longint'(1) << (OW - 1));
    if (v > mx) return OW'(mx);
    if (v < mn) return OW'(mn);
`endif
    return OW'(v);
  endfunction

  function automatic logic exp_sat(input longint v);
`ifdef RESULT_SAT_EN
    longint mx = (longint'(1) << (OW - 1)) - 1;
    longint mn = -(longint'(1) << (OW - 1));
    return (v > mx) || (v < mn);
`else
    return (v != v);
`endif
  endfunction

  always @(posedge clk) begin
    beat_t b;
    if (rst) begin
      q.delete();
      m_have  = '0;
      m_err   = '0;
      m_col   = 0;
      m_ovf   = 1'b0;
      m_mdone = 1'b0;
    end else begin
      m_mdone = 1'b0;
      if (q.size() != 0) begin
        if (pe_done != '0) m_ovf = 1'b1;
        if (out_ready) begin
          void'(q.pop_front());
          if (q.size() == 0) begin
            if (m_col == N - 1) begin
              m_col   = 0;
              m_mdone = 1'b1;
            end else begin
              m_col++;
            end
          end
        end
      end else begin
        for (int p = 0; p < N; p++) begin
          if (pe_done[p]) begin
            if (m_have[p]) m_ovf = 1'b1;
            else begin
              m_have[p] = 1'b1;
              m_tot[p]  = longint'($signed(pe_total[p]));
              m_err[p]  = pe_err[p];
            end
          end
        end
        if (&m_have) begin
          for (int p = 0; p < N; p++) begin
            b.data = exp_data(m_tot[p]);
            b.row  = p;
            b.col  = m_col;
            b.err  = m_err[p];
            b.sat  = exp_sat(m_tot[p]);
            q.push_back(b);
          end
          m_have = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("collect_ready", 32'(collect_ready), 32'(q.size() == 0 && m_have == '0));
      chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
      chk("matrix_done", 32'(matrix_done), 32'(m_mdone));
      if (q.size() != 0 && out_valid) begin
        chk("out_data", 32'(out_data), 32'(q[0].data));
        chk("out_row", 32'(out_row), 32'(q[0].row));
        chk("out_col", 32'(out_col), 32'(q[0].col));
        chk("out_err", 32'(out_err), 32'(q[0].err));
        chk("out_sat", 32'(out_sat), 32'(q[0].sat));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [N-1:0] d, input logic r);
    pe_done   = d;
    out_ready = r;
    @(posedge clk);
    #1;
    pe_done = '0;
  endtask

  task automatic set_tot(input int i, input longint v, input logic e);
    pe_total[i] = AW'(v);
    pe_err[i]   = e;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc('0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic wait_collect(input int bound);
    int k = 0;
    while (!collect_ready && k < bound) begin
      cyc('0, 1'b1);
      k++;
    end
    chk("wait_collect", 32'(collect_ready), 32'd1);
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("rst collect_ready", 32'(collect_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", 32'(out_data), 32'd0);
    chk("rst out_row", 32'(out_row), 32'd0);
    chk("rst out_col", 32'(out_col), 32'd0);
    chk("rst out_err", 32'(out_err), 32'd0);
    chk("rst out_sat", 32'(out_sat), 32'd0);
    chk("rst matrix_done", 32'(matrix_done), 32'd0);
    chk("rst overflow_err", 32'(overflow_err), 32'd0);

    // 1: all dones together, continuous ready
    set_tot(0, 5, 0); set_tot(1, -3, 1); set_tot(2, 7, 0); set_tot(3, 0, 0);
    cyc(4'hF, 1'b1);
    chk("t1 latency valid", 32'(out_valid), 32'd1);
    chk("t1 collect_ready low", 32'(collect_ready), 32'd0);
    chk("t1 row0 data", 32'(out_data), 32'h0005);
    cyc('0, 1'b1);
    chk("t1 row1 data", 32'(out_data), 32'hFFFD);
    chk("t1 row1 err", 32'(out_err), 32'd1);
    chk("t1 row1 row", 32'(out_row), 32'd1);
    cyc('0, 1'b1);
    cyc('0, 1'b1);
    chk("t1 row3 data", 32'(out_data), 32'h0000);
    cyc('0, 1'b1);
    chk("t1 collect_ready back", 32'(collect_ready), 32'd1);
    chk("t1 next col", 32'(out_col), 32'd1);

    // 2: skewed dones PE3, PE0, PE2, PE1 on cycles 0, 2, 5, 9
    set_tot(0, 11, 1); set_tot(1, 22, 0); set_tot(2, 33, 1); set_tot(3, 44, 0);
    for (int c = 0; c < 10; c++) begin
      logic [N-1:0] d;
      d = (c == 0) ? 4'b1000 : (c == 2) ? 4'b0001 : (c == 5) ? 4'b0100 :
          (c == 9) ? 4'b0010 : 4'b0000;
      cyc(d, 1'b1);
      chk("t2 valid timing", 32'(out_valid), (c == 9) ? 32'd1 : 32'd0);
    end
    chk("t2 row0 data", 32'(out_data), 32'd11);
    wait_collect(20);

    // 3: ready 1,0,0,1 during drain
    set_tot(0, 9, 0); set_tot(1, 8, 0); set_tot(2, -7, 1); set_tot(3, 6, 0);
    cyc(4'hF, 1'b1);
    cyc('0, 1'b1);
    cyc('0, 1'b0);
    chk("t3 stall row", 32'(out_row), 32'd1);
    cyc('0, 1'b0);
    chk("t3 stall row hold", 32'(out_row), 32'd1);
    chk("t3 stall data hold", 32'(out_data), 32'd8);
    cyc('0, 1'b1);
    chk("t3 after stall row", 32'(out_row), 32'd2);
    wait_collect(20);

    // 4: five columns back-to-back from a fresh reset
    do_reset();
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) set_tot(i, c * 10 + i, 1'(i & 1));
      cyc(4'hF, 1'b1);
      chk("t4 column index", 32'(out_col), (c == 4) ? 32'd0 : 32'(c));
      for (int i = 0; i < N; i++) cyc('0, 1'b1);
      chk("t4 matrix_done", 32'(matrix_done), (c == 3) ? 32'd1 : 32'd0);
    end

    // 5: overflow on a repeated done and on a done during drain
    do_reset();
    set_tot(1, 100, 0);
    cyc(4'b0010, 1'b1);
    set_tot(1, 200, 1);
    cyc(4'b0010, 1'b1);
    chk("t5 ovf dup", 32'(overflow_err), 32'd1);
    set_tot(0, 1, 0); set_tot(2, 2, 0); set_tot(3, 3, 0);
    cyc(4'b1101, 1'b1);
    chk("t5 drain start", 32'(out_valid), 32'd1);
    cyc(4'b0001, 1'b1);
    chk("t5 first value kept", 32'(out_data), 32'd100);
    chk("t5 first err kept", 32'(out_err), 32'd0);
    chk("t5 ovf sticky", 32'(overflow_err), 32'd1);
    cyc('0, 1'b1);
    rst = 1'b1;
    cyc('0, 1'b1);
    rst = 1'b0;
    chk("t5 rst valid", 32'(out_valid), 32'd0);
    chk("t5 rst ovf", 32'(overflow_err), 32'd0);
    chk("t5 rst row", 32'(out_row), 32'd0);
    chk("t5 rst collect_ready", 32'(collect_ready), 32'd1);

    // 6: narrowing of out-of-range totals
    set_tot(0, 70000, 0); set_tot(1, -70000, 0); set_tot(2, 1, 0); set_tot(3, -1, 0);
    cyc(4'hF, 1'b1);
`ifdef RESULT_SAT_EN
    chk("t6 pos data", 32'(out_data), 32'h7FFF);
    chk("t6 pos sat", 32'(out_sat), 32'd1);
`else
    chk("t6 pos data", 32'(out_data), 32'h1170);
    chk("t6 pos sat", 32'(out_sat), 32'd0);
`endif
    cyc('0, 1'b1);
`ifdef RESULT_SAT_EN
    chk("t6 neg data", 32'(out_data), 32'h8000);
    chk("t6 neg sat", 32'(out_sat), 32'd1);
`else
    chk("t6 neg data", 32'(out_data), 32'hEE90);
    chk("t6 neg sat", 32'(out_sat), 32'd0);
`endif
    cyc('0, 1'b1);
    chk("t6 in-range sat", 32'(out_sat), 32'd0);
    wait_collect(20);
    cyc('0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_result_drain.md
# pe_result_drain

Downstream stage of the PE array. Captures the `total` and `err` results of N parallel PEs, one per row i, each of which computes one dot product for column j. Once all N results of a column are held, it serializes C[0..N-1, j] onto a valid/ready stream, advances the column index, and throttles the controller through `collect_ready`.

## Interface
Parameters:
- `N`, 8: PE count, which is also the matrix dimension.
- `ACCUM_WIDTH`, 32: width of a PE `total`.
- `OUT_WIDTH`, 32: width of the output element. Requires OUT_WIDTH ≤ ACCUM_WIDTH.
- `IDX_WIDTH`, derived: `(N<=1) ? 1 : $clog2(N)`. Localparam, not overridable.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, **synchronous and active-high**.
- `pe_done` in N: per-PE 1-cycle done pulse.
- `pe_total` in N×ACCUM_WIDTH: signed result per PE.
- `pe_err` in N: per-PE error, sampled together with `pe_done`.
- `collect_ready` out 1: controller may issue PE `start`.
- `out_valid` out 1: an element is presented.
- `out_ready` in 1: consumer accepts the element.
- `out_data` out OUT_WIDTH: signed C[i,j].
- `out_row` out IDX_WIDTH: i.
- `out_col` out IDX_WIDTH: j.
- `out_err` out 1: that PE's captured err for this element.
- `out_sat` out 1: element was clamped (see Configuration).
- `matrix_done` out 1: 1-cycle pulse after the last element of column N-1.
- `overflow_err` out 1: sticky; a `pe_done` arrived into an occupied slot.

## Operation
- State machine, two states:
  - **COLLECT**: for each PE p, `pe_done[p]` writes `cap_total[p]`, `cap_err[p]` and sets `cap_vld[p]`. PEs may finish on different cycles. When the OR of current `cap_vld` and current `pe_done` covers all N bits, the FSM moves to DRAIN on that same edge and `row` is set to 0.
  - **DRAIN**: `out_valid=1`. `out_data`, `out_err` and `out_sat` are taken from `cap_*[row]`.
    - On `out_valid & out_ready`: `row++`.
    - When that handshake happens at `row==N-1`: clear all `cap_vld`, set `row` to 0, go to COLLECT, and advance `col`. `col` wraps N-1→0; on that wrap `matrix_done` pulses.
- `collect_ready = (state==COLLECT) && (cap_vld==0)`.
- `overflow_err` sets when either of these occurs:
  - `pe_done[p]` while `cap_vld[p]` is already set.
  - any `pe_done` while in DRAIN.

  The offending sample is dropped. The flag is cleared only by `rst`.
- `out_row` is `row`. `out_col` is `col`.
- Output payload is stable while `out_valid & ~out_ready`.

## Timing
- Reset values: `collect_ready=1`, `out_valid=0`, `out_data=0`, `out_row=0`, `out_col=0`, `out_err=0`, `out_sat=0`, `matrix_done=0`, `overflow_err=0`. The state is COLLECT and every `cap_*` is 0.
- Latency: with the last `pe_done` sampled at edge E, `out_valid` is high in the cycle after E.
- Throughput: one element per cycle while `out_ready=1`. A column takes N cycles of drain plus 1 cycle for the COLLECT turnaround at minimum.
- `matrix_done` is registered. It is high in the cycle following the final handshake, which is the same cycle `collect_ready` returns to 1.
- `rst` asserted mid-drain: on the next edge every register returns to its reset value and the partial column is discarded.
- N=1: every column completes on a single `pe_done`. `matrix_done` pulses after every element.

## Configuration
- `RESULT_SAT_EN` defined: `out_data` is `cap_total` saturated to signed OUT_WIDTH.
  - Above max gives `2^(OUT_WIDTH-1)-1`. Below min gives `-2^(OUT_WIDTH-1)`.
  - `out_sat=1` when clamping occurred.
- `RESULT_SAT_EN` undefined: `out_data` is the low OUT_WIDTH bits, truncated, and `out_sat` is tied to 0.
- When OUT_WIDTH==ACCUM_WIDTH both builds behave identically.

## Structure
- Shared package `pe_pkg` holds:
  - `drain_state_e` enum: COLLECT, DRAIN.
  - `pe_idx_width(N)` function, used for IDX_WIDTH.
- One sub-module, `result_saturate`: combinational, ACCUM_WIDTH in, OUT_WIDTH out, plus a `sat` flag. Its body is under `RESULT_SAT_EN`.

## Test plan
1. N=4, all `pe_done` in one cycle, totals {5,-3,7,0}, `out_ready=1` → four beats row 0..3 with data 5,-3,7,0 and col=0. `out_valid` is high the cycle after the dones; `collect_ready` is low for the four cycles, then high.
2. Skewed dones for PE3, PE0, PE2, PE1 on cycles 0, 2, 5, 9 → no `out_valid` before cycle 10, and the beats come out in row order 0..3.
3. `out_ready` toggling 1,0,0,1 during drain → payload held while stalled, no beat dropped or duplicated.
4. Four full columns back-to-back → `out_col` reads 0,1,2,3. `matrix_done` pulses exactly once, after the last beat of col 3, and the next column reports col=0.
5. `pe_done[1]` pulsed twice before drain, and a `pe_done` during DRAIN → `overflow_err=1` and stays 1. The first captured value is kept. `rst` clears the flag.
6. OUT_WIDTH=16, total=70000 / -70000:
   - With `RESULT_SAT_EN`: outputs 32767 / -32768, `out_sat=1`.
   - Without it: outputs 4464 / -4464, `out_sat=0`.
